// File: rtl/fetch_pair_queue.sv
// Dual-issue instruction queue between fetch and dual decode.
// Accepts up to two words per cycle and presents the two oldest entries as decode slots 1 and 2.
module fetch_pair_queue #(
    parameter int unsigned DEPTH = 8,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       FetchValidF,
    input  logic                       InstrValidF2,
    input  logic [31:0]                InstrF1,
    input  logic [31:0]                InstrF2,
    input  logic [31:0]                PCF,
    output logic                       FetchReadyF,
    input  logic                       StallD,
    input  logic                       StallPipeline2,
    input  logic                       FlushD,
    output logic [31:0]                InstrD1,
    output logic [31:0]                InstrD2,
    output logic [31:0]                PCD1,
    output logic [31:0]                PCD2,
    output logic                       ValidD1,
    output logic                       ValidD2,
    output logic [$clog2(DEPTH):0]     CountQ
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   pc_d    [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          fetch_ready;
    logic          push;
    logic [AW-1:0] tail_p1;
    logic [AW-1:0] head_p1;
    logic [CW-1:0] push_n;
    logic [CW-1:0] pop_req;
    logic [CW-1:0] pop_n;

    assign fetch_ready = (count_q <= READY_MAX);
    assign push        = FetchValidF && fetch_ready && !FlushD;
    assign tail_p1     = tail_q + AW'(1);
    assign head_p1     = head_q + AW'(1);

    always_comb begin
        push_n = '0;
        if (push) begin
            push_n = InstrValidF2 ? CW'(2) : CW'(1);
        end

        if (StallD) begin
            pop_req = '0;
        end else if (StallPipeline2) begin
            pop_req = CW'(1);
        end else begin
            pop_req = CW'(2);
        end
        // pop is bounded by occupancy before this cycle's push
        pop_n = (pop_req > count_q) ? count_q : pop_req;
    end

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (push) begin
            instr_d[tail_q] = InstrF1;
            pc_d[tail_q]    = PCF;
            if (InstrValidF2) begin
                instr_d[tail_p1] = InstrF2;
                pc_d[tail_p1]    = PCF + 32'd4;
            end
        end
    end

    always_comb begin
        if (FlushD) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(pop_n);
            tail_d  = tail_q + AW'(push_n);
            count_d = count_q + push_n - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // storage needs no reset; occupancy gates visibility
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    always_comb begin
        ValidD1     = (count_q != '0);
        ValidD2     = (count_q > CW'(1));
        InstrD1     = ValidD1 ? instr_q[head_q]  : NOP;
        PCD1        = ValidD1 ? pc_q[head_q]     : 32'd0;
        InstrD2     = ValidD2 ? instr_q[head_p1] : NOP;
        PCD2        = ValidD2 ? pc_q[head_p1]    : 32'd0;
        FetchReadyF = fetch_ready;
        CountQ      = count_q;
    end

endmodule
